// File: rtl/gs_lsu.sv
// gs_lsu: load/store unit between EX and a req/gnt/rvalid data-memory port, with load alignment and writeback.
// Optional macro GS_LSU_MISALIGN_TRAP_EN: trap misaligned H/W accesses instead of issuing them.
module gs_lsu #(
  parameter int ADDR_SIZE    = 32,
  parameter int WORD_SIZE    = 32,
  parameter int RESP_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ex_valid_i,
  input  logic                 ex_MemRead_i,
  input  logic                 ex_MemWrite_i,
  input  logic [2:0]           ex_DataSize_i,
  input  logic [ADDR_SIZE-1:0] ex_data_addr_i,
  input  logic [WORD_SIZE-1:0] ex_rs2_data_i,
  input  logic                 ex_RegWrite_i,
  input  logic [4:0]           ex_rd_addr_i,
  input  logic [WORD_SIZE-1:0] ex_rd_data_i,
  output logic                 dmem_req_o,
  output logic                 dmem_we_o,
  output logic [3:0]           dmem_be_o,
  output logic [ADDR_SIZE-1:0] dmem_addr_o,
  output logic [WORD_SIZE-1:0] dmem_wdata_o,
  input  logic                 dmem_gnt_i,
  input  logic                 dmem_rvalid_i,
  input  logic [WORD_SIZE-1:0] dmem_rdata_i,
  output logic                 lsu_halt_o,
  output logic                 lsu_bus_err_o,
  output logic                 lsu_misalign_o,
  output logic                 wb_valid_o,
  output logic                 wb_RegWrite_o,
  output logic [4:0]           wb_rd_addr_o,
  output logic [WORD_SIZE-1:0] wb_rd_data_o
);

  localparam int CW = $clog2(RESP_TIMEOUT);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  // What the load path still needs once the request has left.
  typedef struct packed {
    logic [2:0] size;
    logic [1:0] ofs;
    logic       rw;
    logic [4:0] rd;
  } op_t;

  state_t         state;
  op_t            op;
  logic [CW-1:0]  cnt;

  logic [1:0]           a;
  logic                 mem_op;
  logic                 trap;
  logic [3:0]           be_nxt;
  logic [WORD_SIZE-1:0] wd_nxt;
  logic [WORD_SIZE-1:0] lane;
  logic [WORD_SIZE-1:0] ld_ext;
  logic                 sx;

  assign a          = ex_data_addr_i[1:0];
  assign mem_op     = ex_valid_i & (ex_MemRead_i | ex_MemWrite_i);
  assign lsu_halt_o = (state != IDLE);

`ifdef GS_LSU_MISALIGN_TRAP_EN
  assign trap = ((ex_DataSize_i[1:0] == 2'b01) && a[0]) || (ex_DataSize_i[1] && (a != 2'b00));
`else
  assign trap           = 1'b0;
  assign lsu_misalign_o = 1'b0;
`endif

  // Byte-lane steering for stores; reserved sizes fall through to word.
  always_comb begin
    be_nxt = 4'b1111;
    wd_nxt = ex_rs2_data_i;
    case (ex_DataSize_i[1:0])
      2'b00: begin
        be_nxt = 4'b0001 << a;
        wd_nxt = {4{ex_rs2_data_i[7:0]}};
      end
      2'b01: begin
        be_nxt = 4'b0011 << {a[1], 1'b0};
        wd_nxt = {2{ex_rs2_data_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Load alignment and extension, driven straight off the returning bus data.
  always_comb begin
    case (op.size[1:0])
      2'b00:   lane = dmem_rdata_i >> {op.ofs, 3'b000};
      2'b01:   lane = dmem_rdata_i >> {op.ofs[1], 4'b0000};
      default: lane = dmem_rdata_i;
    endcase
    sx = ~op.size[2];
    case (op.size[1:0])
      2'b00:   ld_ext = {{24{sx & lane[7]}}, lane[7:0]};
      2'b01:   ld_ext = {{16{sx & lane[15]}}, lane[15:0]};
      default: ld_ext = lane;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      op            <= '0;
      cnt           <= '0;
      dmem_req_o    <= 1'b0;
      dmem_we_o     <= 1'b0;
      dmem_be_o     <= '0;
      dmem_addr_o   <= '0;
      dmem_wdata_o  <= '0;
      lsu_bus_err_o <= 1'b0;
      wb_valid_o    <= 1'b0;
      wb_RegWrite_o <= 1'b0;
      wb_rd_addr_o  <= '0;
      wb_rd_data_o  <= '0;
`ifdef GS_LSU_MISALIGN_TRAP_EN
      lsu_misalign_o <= 1'b0;
`endif
    end else begin
      wb_valid_o    <= 1'b0;
      wb_RegWrite_o <= 1'b0;
      lsu_bus_err_o <= 1'b0;
`ifdef GS_LSU_MISALIGN_TRAP_EN
      lsu_misalign_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (mem_op && trap) begin
`ifdef GS_LSU_MISALIGN_TRAP_EN
            lsu_misalign_o <= 1'b1;
`endif
          end else if (mem_op) begin
            // Read wins when both strobes are set.
            op           <= '{size: ex_DataSize_i, ofs: a, rw: ex_RegWrite_i, rd: ex_rd_addr_i};
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= ex_MemWrite_i & ~ex_MemRead_i;
            dmem_be_o    <= be_nxt;
            dmem_addr_o  <= {ex_data_addr_i[ADDR_SIZE-1:2], 2'b00};
            dmem_wdata_o <= wd_nxt;
            state        <= REQ;
          end else if (ex_valid_i) begin
            wb_valid_o    <= 1'b1;
            wb_RegWrite_o <= ex_RegWrite_i;
            wb_rd_addr_o  <= ex_rd_addr_i;
            wb_rd_data_o  <= ex_rd_data_i;
          end
        end
        REQ: begin
          if (dmem_gnt_i) begin
            dmem_req_o <= 1'b0;
            if (dmem_we_o) begin
              wb_valid_o   <= 1'b1;
              wb_rd_addr_o <= op.rd;
              state        <= IDLE;
            end else begin
              cnt   <= '0;
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (dmem_rvalid_i) begin
            wb_valid_o    <= 1'b1;
            wb_RegWrite_o <= op.rw;
            wb_rd_addr_o  <= op.rd;
            wb_rd_data_o  <= ld_ext;
            state         <= IDLE;
          end else if (cnt == CW'(RESP_TIMEOUT - 1)) begin
            lsu_bus_err_o <= 1'b1;
            state         <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
